// File: rtl/core_pkg.sv
// Shared core types and constants for the barrel-threaded pipeline.
package core_pkg;

  localparam int XLEN = 32;
  localparam int MAX_THREADS = 16;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef logic [$clog2(MAX_THREADS)-1:0] thread_idx_t;

  function automatic logic [XLEN-1:0] pc_align(
    input logic [XLEN-1:0] pc
  );
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/thread_pc_file.sv
// Per-thread PC register file: one async read port, increment and
// redirect write ports (redirect wins on collision).
module thread_pc_file
  import core_pkg::*;
#(
  parameter int NUM_THREADS = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int TW = $clog2(NUM_THREADS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [TW-1:0]   rd_addr_i,
  output logic [XLEN-1:0] rd_data_o,
  input  logic            inc_en_i,
  input  logic [TW-1:0]   inc_addr_i,
  input  logic [XLEN-1:0] inc_data_i,
  input  logic            rdr_en_i,
  input  logic [TW-1:0]   rdr_addr_i,
  input  logic [XLEN-1:0] rdr_data_i
);

  logic [XLEN-1:0] pc_q [NUM_THREADS];
  logic [XLEN-1:0] pc_d [NUM_THREADS];

  assign rd_data_o = pc_q[rd_addr_i];

  always_comb begin
    pc_d = pc_q;
    if (inc_en_i) pc_d[inc_addr_i] = inc_data_i;
    // later write overrides the increment on the same thread
    if (rdr_en_i) pc_d[rdr_addr_i] = rdr_data_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= RESET_PC;
      end
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/barrel_fetch_sched.sv
// Round-robin barrel fetch stage: slot counter plus F1/F2 pipeline.
// Optional per-thread enable mask under BARREL_THREAD_MASK_EN.
module barrel_fetch_sched
  import core_pkg::*;
#(
  parameter int NUM_THREADS = 16,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_ADDR_WIDTH = 10,
  localparam int TW = $clog2(NUM_THREADS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_redirect_valid,
  input  logic [TW-1:0]              i_redirect_thread,
  input  logic [XLEN-1:0]            i_redirect_pc,
`ifdef BARREL_THREAD_MASK_EN
  input  logic [NUM_THREADS-1:0]     i_thread_en,
`endif
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic                       o_imem_en,
  output logic [TW-1:0]              o_thread_index,
  output logic [XLEN-1:0]            o_pc,
  output logic                       o_valid
);

  logic [TW-1:0]              slot_q, slot_d;
  logic [TW-1:0]              f1_slot_q;
  logic [XLEN-1:0]            f1_pc_q;
  logic                       f1_valid_q;
  logic [IMEM_ADDR_WIDTH-1:0] addr_q;
  logic                       en_q;
  logic [TW-1:0]              f2_slot_q;
  logic [XLEN-1:0]            f2_pc_q;
  logic                       f2_valid_q;
  logic [XLEN-1:0]            pc_rd;
  logic                       slot_en;

`ifdef BARREL_THREAD_MASK_EN
  assign slot_en = i_thread_en[slot_q];
`else
  assign slot_en = 1'b1;
`endif

  assign slot_d = slot_q + TW'(1);

  thread_pc_file #(
    .NUM_THREADS (NUM_THREADS),
    .RESET_PC    (RESET_PC)
  ) u_pcf (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_addr_i  (slot_q),
    .rd_data_o  (pc_rd),
    .inc_en_i   (slot_en),
    .inc_addr_i (slot_q),
    .inc_data_i (pc_rd + PC_INC),
    .rdr_en_i   (i_redirect_valid),
    .rdr_addr_i (i_redirect_thread),
    .rdr_data_i (pc_align(i_redirect_pc))
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_q     <= '0;
      f1_slot_q  <= '0;
      f1_pc_q    <= '0;
      f1_valid_q <= 1'b0;
      addr_q     <= '0;
      en_q       <= 1'b0;
      f2_slot_q  <= '0;
      f2_pc_q    <= '0;
      f2_valid_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      f1_slot_q  <= slot_q;
      f1_pc_q    <= pc_rd;
      f1_valid_q <= slot_en;
      addr_q     <= pc_rd[IMEM_ADDR_WIDTH+1:2];
      en_q       <= slot_en;
      f2_slot_q  <= f1_slot_q;
      f2_pc_q    <= f1_pc_q;
      f2_valid_q <= f1_valid_q;
    end
  end

  assign o_imem_addr    = addr_q;
  assign o_imem_en      = en_q;
  assign o_thread_index = f2_slot_q;
  assign o_pc           = f2_pc_q;
  assign o_valid        = f2_valid_q;

endmodule
